// File: rtl/distributor8.sv
// Two-channel word distributor: routes each accepted upstream byte into FIFO A or B,
// either by a per-word select or by round-robin, and counts the words accepted per channel.
module distributor8 #(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_s,
  input  logic       i_mode,
  output logic       o_ready,
  output logic       o_a_valid,
  output logic [7:0] o_a_data,
  input  logic       i_a_ready,
  output logic [7:0] o_a_cnt,
  output logic       o_b_valid,
  output logic [7:0] o_b_data,
  input  logic       i_b_ready,
  output logic [7:0] o_b_cnt
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    r_a_mem [DEPTH];
  logic [7:0]    r_b_mem [DEPTH];
  logic [AW-1:0] r_a_wp, r_a_rp, r_b_wp, r_b_rp;
  logic [AW:0]   r_a_occ, r_b_occ;
  logic [7:0]    r_a_cnt, r_b_cnt;
  logic          r_rr;

  logic w_target, w_ready, w_acc;
  logic w_a_push, w_a_pop, w_b_push, w_b_pop;
  logic w_a_nempty, w_b_nempty;

  // Routing, acceptance and pop decisions; ready looks only at the target's fullness
  always_comb begin
    w_target   = 1'b0;
    w_ready    = 1'b0;
    w_a_nempty = (r_a_occ != '0);
    w_b_nempty = (r_b_occ != '0);
    if (i_mode) begin
      w_target = r_rr;
    end else begin
      w_target = i_s;
    end
    if (w_target) begin
      w_ready = (r_b_occ != OCC_FULL);
    end else begin
      w_ready = (r_a_occ != OCC_FULL);
    end
    w_acc    = i_valid & w_ready;
    w_a_push = w_acc & ~w_target;
    w_b_push = w_acc & w_target;
    w_a_pop  = w_a_nempty & i_a_ready;
    w_b_pop  = w_b_nempty & i_b_ready;
  end

  assign o_ready   = w_ready;
  assign o_a_valid = w_a_nempty;
  assign o_b_valid = w_b_nempty;
  assign o_a_data  = w_a_nempty ? r_a_mem[r_a_rp] : 8'h00;
  assign o_b_data  = w_b_nempty ? r_b_mem[r_b_rp] : 8'h00;
  assign o_a_cnt   = r_a_cnt;
  assign o_b_cnt   = r_b_cnt;

  // Channel A FIFO and accept counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_wp  <= '0;
      r_a_rp  <= '0;
      r_a_occ <= '0;
      r_a_cnt <= 8'd0;
    end else begin
      if (w_a_push) begin
        r_a_mem[r_a_wp] <= i_data;
        r_a_wp          <= r_a_wp + PTR_ONE;
        r_a_cnt         <= r_a_cnt + 8'd1;
      end
      if (w_a_pop) begin
        r_a_rp <= r_a_rp + PTR_ONE;
      end
      case ({w_a_push, w_a_pop})
        2'b10:   r_a_occ <= r_a_occ + OCC_ONE;
        2'b01:   r_a_occ <= r_a_occ - OCC_ONE;
        default: r_a_occ <= r_a_occ;
      endcase
    end
  end

  // Channel B FIFO and accept counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_b_wp  <= '0;
      r_b_rp  <= '0;
      r_b_occ <= '0;
      r_b_cnt <= 8'd0;
    end else begin
      if (w_b_push) begin
        r_b_mem[r_b_wp] <= i_data;
        r_b_wp          <= r_b_wp + PTR_ONE;
        r_b_cnt         <= r_b_cnt + 8'd1;
      end
      if (w_b_pop) begin
        r_b_rp <= r_b_rp + PTR_ONE;
      end
      case ({w_b_push, w_b_pop})
        2'b10:   r_b_occ <= r_b_occ + OCC_ONE;
        2'b01:   r_b_occ <= r_b_occ - OCC_ONE;
        default: r_b_occ <= r_b_occ;
      endcase
    end
  end

  // Round-robin pointer advances only on an accept made in alternating mode
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr <= 1'b0;
    end else if (w_acc && i_mode) begin
      r_rr <= ~r_rr;
    end else begin
      r_rr <= r_rr;
    end
  end

endmodule

// File: tb/tb_distributor8.sv
// Scoreboard bench for distributor8: a reference model predicts acceptance, FIFO contents
// and counts; popped words are queued as expected/observed pairs and compared per scenario.
module tb_distributor8;
  localparam int DEPTH = 2;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_s, i_mode, i_a_ready, i_b_ready;
  logic [7:0] i_data;
  logic       o_ready, o_a_valid, o_b_valid;
  logic [7:0] o_a_data, o_b_data, o_a_cnt, o_b_cnt;

  logic [7:0] m_a[$];
  logic [7:0] m_b[$];
  logic       m_rr;
  logic [7:0] m_acnt, m_bcnt;
  logic [8:0] pe[$];
  logic [8:0] pg[$];
  int n_vec = 0;
  int n_err = 0;

  distributor8 #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_s(i_s),
    .i_mode(i_mode), .o_ready(o_ready),
    .o_a_valid(o_a_valid), .o_a_data(o_a_data), .i_a_ready(i_a_ready), .o_a_cnt(o_a_cnt),
    .o_b_valid(o_b_valid), .o_b_data(o_b_data), .i_b_ready(i_b_ready), .o_b_cnt(o_b_cnt)
  );

  always #5 i_clk = ~i_clk;

  // one clock of stimulus; model predicts accept/pop before the edge, push after pop
  task automatic apply(input logic v, input logic [7:0] d, input logic s, input logic m,
                       input logic ar, input logic br);
    logic tgt, acc;
    i_valid = v; i_data = d; i_s = s; i_mode = m; i_a_ready = ar; i_b_ready = br;
    #1;
    tgt = m ? m_rr : s;
    acc = v && (tgt ? (m_b.size() < DEPTH) : (m_a.size() < DEPTH));
    if (ar && m_a.size() > 0) begin
      pe.push_back({1'b1, m_a.pop_front()});
      pg.push_back({o_a_valid, o_a_data});
    end
    if (br && m_b.size() > 0) begin
      pe.push_back({1'b1, m_b.pop_front()});
      pg.push_back({o_b_valid, o_b_data});
    end
    if (acc) begin
      if (tgt) begin
        m_b.push_back(d);
        m_bcnt = m_bcnt + 8'd1;
      end else begin
        m_a.push_back(d);
        m_acnt = m_acnt + 8'd1;
      end
      if (m) m_rr = ~m_rr;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'hEE; i_a_ready = 1'b1; i_b_ready = 1'b1;
    i_s = 1'b0; i_mode = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0; i_valid = 1'b0; i_a_ready = 1'b0; i_b_ready = 1'b0;
    m_a.delete(); m_b.delete(); pe.delete(); pg.delete();
    m_rr = 1'b0; m_acnt = 8'd0; m_bcnt = 8'd0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec += 6;
    if (o_a_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %b want 0", o_a_valid); end
    if (o_b_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %b want 0", o_b_valid); end
    if (o_a_data !== 8'h00) begin n_err++; $display("FAIL reset_a_data: got %h want 00", o_a_data); end
    if (o_b_data !== 8'h00) begin n_err++; $display("FAIL reset_b_data: got %h want 00", o_b_data); end
    if ({o_a_cnt, o_b_cnt} !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", o_a_cnt, o_b_cnt); end
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_direct();
    do_reset();
    apply(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    n_vec += 4;
    if (o_b_valid !== 1'b1) begin n_err++; $display("FAIL direct_b_valid: got %b want 1", o_b_valid); end
    if (o_b_data !== 8'h5A) begin n_err++; $display("FAIL direct_b_data: got %h want 5a", o_b_data); end
    if (o_b_cnt !== 8'd1) begin n_err++; $display("FAIL direct_b_cnt: got %0d want 1", o_b_cnt); end
    if (o_a_valid !== 1'b0) begin n_err++; $display("FAIL direct_a_valid: got %b want 0", o_a_valid); end
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    while (pe.size() > 0) begin
      logic [8:0] e, g;
      e = pe.pop_front(); g = pg.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL direct_pop: got %h want %h", g, e); end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 1; i <= 4; i++) apply(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    n_vec += 3;
    if (o_a_cnt !== 8'd2) begin n_err++; $display("FAIL alt_a_cnt: got %0d want 2", o_a_cnt); end
    if (o_b_cnt !== 8'd2) begin n_err++; $display("FAIL alt_b_cnt: got %0d want 2", o_b_cnt); end
    if ({o_a_valid, o_b_valid} !== 2'b00) begin n_err++; $display("FAIL alt_drained: got %b want 00", {o_a_valid, o_b_valid}); end
    while (pe.size() > 0) begin
      logic [8:0] e, g;
      e = pe.pop_front(); g = pg.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL alt_pop: got %h want %h", g, e); end
    end
    // pointer back at 0: next alternating word goes to A despite i_s=1
    apply(1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec += 2;
    if ({o_a_valid, o_a_data} !== 9'h110) begin n_err++; $display("FAIL alt_rr0: got %h want 110", {o_a_valid, o_a_data}); end
    if (o_b_valid !== 1'b0) begin n_err++; $display("FAIL alt_rr0_b: got %b want 0", o_b_valid); end
    // direct-mode word to A leaves the pointer at 1, so the next alternating word goes to B
    apply(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec += 2;
    if ({o_b_valid, o_b_data} !== 9'h112) begin n_err++; $display("FAIL alt_mode_hold: got %h want 112", {o_b_valid, o_b_data}); end
    if (o_b_cnt !== m_bcnt) begin n_err++; $display("FAIL alt_b_cnt2: got %0d want %0d", o_b_cnt, m_bcnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    apply(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b want 0", o_ready); end
    apply(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
    i_s = 1'b1; #1;
    n_vec++;
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b: got %b want 1", o_ready); end
    apply(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec += 2;
    if ({o_b_valid, o_b_data} !== 9'h1B1) begin n_err++; $display("FAIL bp_b_head: got %h want 1b1", {o_b_valid, o_b_data}); end
    if (o_a_cnt !== 8'd2) begin n_err++; $display("FAIL bp_a_cnt: got %0d want 2", o_a_cnt); end
    for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    while (pe.size() > 0) begin
      logic [8:0] e, g;
      e = pe.pop_front(); g = pg.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL bp_pop: got %h want %h", g, e); end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    apply(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (o_ready !== 1'b0) begin n_err++; $display("FAIL fp_ready: got %b want 0", o_ready); end
    apply(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec += 2;
    if (o_a_cnt !== 8'd2) begin n_err++; $display("FAIL fp_no_bypass: got %0d want 2", o_a_cnt); end
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL fp_ready_after: got %b want 1", o_ready); end
    apply(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (o_a_cnt !== 8'd3) begin n_err++; $display("FAIL fp_accept_next: got %0d want 3", o_a_cnt); end
    for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    while (pe.size() > 0) begin
      logic [8:0] e, g;
      e = pe.pop_front(); g = pg.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL fp_pop: got %h want %h", g, e); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) apply(1'b1, 8'(i ^ 8'h3C), 1'b1, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (o_b_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_cnt: got %0d want 0", o_b_cnt); end
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (pe.size() != 256) begin n_err++; $display("FAIL wrap_pops: got %0d want 256", pe.size()); end
    while (pe.size() > 0) begin
      logic [8:0] e, g;
      e = pe.pop_front(); g = pg.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL wrap_pop: got %h want %h", g, e); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    apply(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'hD2, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'hD3, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    n_vec += 3;
    if ({o_a_valid, o_b_valid} !== 2'b00) begin n_err++; $display("FAIL mr_valid: got %b want 00", {o_a_valid, o_b_valid}); end
    if ({o_a_cnt, o_b_cnt} !== 16'h0000) begin n_err++; $display("FAIL mr_cnt: got %h/%h want 0/0", o_a_cnt, o_b_cnt); end
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %b want 1", o_ready); end
    apply(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec += 3;
    if ({o_a_valid, o_a_data} !== 9'h177) begin n_err++; $display("FAIL mr_route_a: got %h want 177", {o_a_valid, o_a_data}); end
    if (o_b_valid !== 1'b0) begin n_err++; $display("FAIL mr_b_valid: got %b want 0", o_b_valid); end
    if (o_a_cnt !== 8'd1) begin n_err++; $display("FAIL mr_a_cnt: got %0d want 1", o_a_cnt); end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_s = 1'b0; i_mode = 1'b0;
    i_a_ready = 1'b0; i_b_ready = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_direct();
    test_alternate();
    test_backpressure();
    test_full_pop();
    test_wrap();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/distributor8.md
DISTRIBUTOR8 -- requirements
Module: distributor8

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the entries per output FIFO; legal values are powers of two from 2 to 16.
REQ-002 Port i_clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port i_rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port i_valid, input, 1 bit, SHALL flag that the upstream word is valid.
REQ-005 Port i_data, input, 8 bits, SHALL carry the upstream word.
REQ-006 Port i_s, input, 1 bit, SHALL be the per-word route select in direct mode: 0 selects channel A, 1 selects channel B.
REQ-007 Port i_mode, input, 1 bit, SHALL select the routing mode: 0 is direct (by i_s), 1 is alternating (round-robin).
REQ-008 Port o_ready, output, 1 bit, SHALL flag that the block can accept the upstream word this cycle.
REQ-009 Ports o_a_valid and o_b_valid, outputs, 1 bit each, SHALL flag that the channel head word is valid.
REQ-010 Ports o_a_data and o_b_data, outputs, 8 bits each, SHALL carry the channel head word.
REQ-011 Ports i_a_ready and i_b_ready, inputs, 1 bit each, SHALL flag that downstream takes the channel head word.
REQ-012 Ports o_a_cnt and o_b_cnt, outputs, 8 bits each, SHALL give the count of words accepted into each channel.

Function
REQ-013 Target SHALL be i_s when i_mode=0 and rr_ptr when i_mode=1 (combinational).
REQ-014 o_ready SHALL equal NOT full(target FIFO); it SHALL NOT depend on i_valid or the downstream ready of the same cycle.
REQ-015 Accept SHALL occur when i_valid=1 and o_ready=1; the word is written to the target FIFO tail at that edge.
REQ-016 A full FIFO SHALL NOT accept a word even if it pops in the same cycle (no bypass).
REQ-017 Each accept SHALL increment the target channel count by 1, modulo 256 (255 -> 0).
REQ-018 In mode 1, each accept SHALL toggle rr_ptr; rr_ptr SHALL NOT change without an accept, in mode 0, or while the target is full.
REQ-019 On a mode change, rr_ptr SHALL hold its value; alternation resumes from the held value.
REQ-020 o_x_valid SHALL be 1 exactly when FIFO x is non-empty; o_x_data SHALL be the head word when valid and 8'h00 when empty.
REQ-021 Pop SHALL occur when o_x_valid=1 and i_x_ready=1; i_x_ready with an empty FIFO SHALL have no effect.
REQ-022 Latency SHALL be one cycle: a word accepted at edge N is presented as head at edge N only if the FIFO was empty; otherwise it follows FIFO order.
REQ-023 A simultaneous push and pop on the same FIFO SHALL leave the occupancy unchanged and preserve order.
REQ-024 Channels SHALL be independent: a stalled channel blocks only words targeted at it; o_ready re-evaluates when i_s changes.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range over 0..DEPTH.
REQ-026 Words SHALL leave each channel in acceptance order and none shall be lost or duplicated.

Reset
REQ-027 While i_rst=1 at an edge, the block SHALL empty both FIFOs, set counts to 0, set rr_ptr to 0, and ignore i_valid, i_a_ready and i_b_ready.
REQ-028 In the cycle after reset, outputs SHALL be o_a_valid=o_b_valid=0, o_a_data=o_b_data=8'h00, o_a_cnt=o_b_cnt=0, and o_ready=1.
REQ-029 Reset during transfer SHALL discard all buffered words, with no partial output.

Verification
REQ-030 Direct routing: mode 0, i_s=1, i_data=8'h5A accepted with i_b_ready=1 -> next cycle o_b_valid=1, o_b_data=8'h5A, o_b_cnt=1, o_a_valid=0.
REQ-031 Alternating routing: mode 1, words 8'h01..8'h04 sent back-to-back with both downstream readies high -> A receives 01,03; B receives 02,04; counts 2/2; rr_ptr=0.
REQ-032 Backpressure isolation: DEPTH=2, i_a_ready=0, mode 0, three words sent with i_s=0 -> o_ready=0 after two words; a word with i_s=1 is still accepted to B; A then drains in order after i_a_ready=1.
REQ-033 Full-with-pop: FIFO A full and i_a_ready=1 in the same cycle as a word targeted at A -> that word is not accepted; it is accepted the next cycle.
REQ-034 Counter wrap: 256 words accepted into B -> o_b_cnt=0 and no word lost.
REQ-035 Mid-run reset: i_rst asserted with both FIFOs holding data -> next cycle both valids 0, counts 0, o_ready=1, and a new word is routed to A in mode 1.
